// File: rtl/custom_pkg.sv
// Shared types and constants for the RV32 pipeline: control word, memory-stage
// FSM states, load/store funct3 encodings and the pipeline bubble value.
package custom_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'd0;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic [1:0] wb_sel;
    logic       rf_we;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] mem_funct3;
  } control_t;

  // addi x0, x0, 0
  localparam control_t MI_ADDI = '{
    alu_op:     ALU_ADD,
    alu_src:    1'b1,
    wb_sel:     2'b00,
    rf_we:      1'b1,
    mem_rd:     1'b0,
    mem_wr:     1'b0,
    mem_funct3: F3_B
  };

endpackage

// File: rtl/memory_access_lsu_align.sv
// Byte-lane steering for loads and stores: byte enables, replicated store
// data, misalignment detection and sign/zero-extended load extraction.
module lsu_align
  import custom_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    be       = '0;
    wdata    = store_data;
    misalign = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be       = 4'b0011 << off;
        wdata    = {2{store_data[15:0]}};
        misalign = off[0];
      end
      default: begin
        be       = 4'b1111;
        misalign = (off != 2'b00);
      end
    endcase
  end

  always_comb begin
    shifted   = rdata >> {off, 3'b000};
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: runs loads/stores on a req/gnt/rvalid bus,
// stalls upstream while a transaction is outstanding, registers the result.
module memory_access
  import custom_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  control_t    control_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] mem_data_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [4:0]  addr_rd_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output control_t    control_o,
  output logic [4:0]  addr_rd_o,
  output logic [31:0] alu_o,
  output logic [31:0] load_data_o,
  output logic [31:0] pc_plus4_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mem_state_t  state, state_next;
  logic [CW-1:0] cnt;

  logic        memop, issue, misalign, timeout, rsp, busy;
  logic [3:0]  be;
  logic [31:0] wdata, ext_data;
  control_t    ctrl_next;

  lsu_align u_align (
    .off        (alu_i[1:0]),
    .funct3     (control_i.mem_funct3),
    .store_data (mem_data_i),
    .rdata      (dmem_rdata_i),
    .be         (be),
    .wdata      (wdata),
    .misalign   (misalign),
    .load_data  (ext_data)
  );

  always_comb begin
    memop = valid_i & (control_i.mem_rd | control_i.mem_wr);
    issue = memop & ~misalign;
    rsp   = (state == S_WAIT) & dmem_rvalid_i;
    // A grant arriving on the last request cycle wins over the timeout so
    // that req is never withdrawn before it has been accepted.
    timeout = (state != S_IDLE) & (cnt == CNT_LAST)
            & ~((state == S_REQ) & dmem_gnt_i);

    busy       = 1'b0;
    state_next = state;
    case (state)
      S_IDLE: begin
        busy = issue;
        if (issue) state_next = dmem_gnt_i ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        busy = ~timeout;
        if (dmem_gnt_i)   state_next = S_WAIT;
        else if (timeout) state_next = S_IDLE;
      end
      S_WAIT: begin
        busy = ~dmem_rvalid_i & ~timeout;
        if (dmem_rvalid_i | timeout) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    stall_o    = busy & ~rst_i;
    // Gated by reset so an asynchronous reset drops the request at once,
    // even though the held instruction would otherwise re-issue from idle.
    dmem_req_o = ~rst_i & (((state == S_IDLE) & issue) | (state == S_REQ));

    dmem_we_o    = dmem_req_o & control_i.mem_wr;
    dmem_addr_o  = dmem_req_o ? {alu_i[31:2], 2'b00} : '0;
    dmem_be_o    = dmem_req_o ? be : '0;
    dmem_wdata_o = dmem_req_o ? wdata : '0;

    ctrl_next = valid_i ? control_i : MI_ADDI;
    if ((memop & misalign) | timeout) ctrl_next.rf_we = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (state != S_IDLE) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o     <= 1'b0;
      control_o   <= MI_ADDI;
      addr_rd_o   <= '0;
      alu_o       <= '0;
      load_data_o <= '0;
      pc_plus4_o  <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else if (busy) begin
      valid_o     <= 1'b0;
      control_o   <= MI_ADDI;
      addr_rd_o   <= '0;
      alu_o       <= '0;
      load_data_o <= '0;
      pc_plus4_o  <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      valid_o     <= valid_i;
      control_o   <= ctrl_next;
      addr_rd_o   <= addr_rd_i;
      alu_o       <= alu_i;
      load_data_o <= (rsp & control_i.mem_rd) ? ext_data : '0;
      pc_plus4_o  <= pc_plus4_i;
      misalign_o  <= memop & misalign;
      bus_err_o   <= timeout;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed testbench for memory_access with hand-computed expectations.
module tb_memory_access;
  import custom_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  control_t    control_i;
  logic [31:0] alu_i, mem_data_i, pc_plus4_i;
  logic [4:0]  addr_rd_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  control_t    control_o;
  logic [4:0]  addr_rd_o;
  logic [31:0] alu_o, load_data_o, pc_plus4_o;
  logic        misalign_o, bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  memory_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .control_i    (control_i),
    .alu_i        (alu_i),
    .mem_data_i   (mem_data_i),
    .pc_plus4_i   (pc_plus4_i),
    .addr_rd_i    (addr_rd_i),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_gnt_i   (dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i (dmem_rdata_i),
    .valid_o      (valid_o),
    .control_o    (control_o),
    .addr_rd_o    (addr_rd_o),
    .alu_o        (alu_o),
    .load_data_o  (load_data_o),
    .pc_plus4_o   (pc_plus4_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic control_t mk_ctrl(input logic rd, input logic wr, input logic [2:0] f3);
    control_t c;
    c            = MI_ADDI;
    c.alu_src    = 1'b1;
    c.rf_we      = ~wr;
    c.mem_rd     = rd;
    c.mem_wr     = wr;
    c.mem_funct3 = f3;
    return c;
  endfunction

  // gd: cycles before gnt (0 = issue cycle); rd: cycles from gnt to rvalid.
  task automatic run_mem(input string tag, input control_t c, input logic [31:0] addr,
                         input logic [31:0] sdata, input int gd, input int rd,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    int stalls = 0;
    @(negedge clk);
    valid_i = 1'b1; control_i = c; alu_i = addr; mem_data_i = sdata;
    addr_rd_i = 5'd7; pc_plus4_i = 32'h0000_1004;
    for (int k = 0; k <= gd + rd; k++) begin
      if (k > 0) @(negedge clk);
      dmem_gnt_i    = (k == gd);
      dmem_rvalid_i = (k == gd + rd);
      dmem_rdata_i  = (k == gd + rd) ? rdata : 32'hDEAD_BEEF;
      #1;
      if (k <= gd) begin
        check({tag, " bus ctl"}, {27'h0, dmem_req_o, dmem_we_o, dmem_be_o},
              {27'h0, 1'b1, c.mem_wr, exp_be});
        check({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        check({tag, " wdata"}, dmem_wdata_o, exp_wdata);
      end else begin
        check({tag, " req low"}, {31'h0, dmem_req_o}, 32'h0);
      end
      if (k > 0) check({tag, " bubble"}, {31'h0, valid_o}, 32'h0);
      if (stall_o) stalls++;
    end
    @(negedge clk);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; valid_i = 1'b0;
    #1;
    check({tag, " stalls"}, stalls, gd + rd);
    check({tag, " valid_o"}, {31'h0, valid_o}, 32'h1);
    check({tag, " load_data"}, load_data_o, exp_load);
    check({tag, " flags"}, {30'h0, misalign_o, bus_err_o}, 32'h0);
  endtask

  initial begin
    int stalls;
    control_t alu_c;
    rst_i = 1'b1; valid_i = 1'b0; control_i = MI_ADDI; alu_i = '0; mem_data_i = '0;
    pc_plus4_i = '0; addr_rd_i = '0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk);
    check("rst valid_o", {31'h0, valid_o}, 32'h0);
    check("rst control_o", 32'(control_o), 32'(MI_ADDI));
    check("rst req/stall", {30'h0, dmem_req_o, stall_o}, 32'h0);
    check("rst flags", {30'h0, misalign_o, bus_err_o}, 32'h0);
    rst_i = 1'b0;

    // ALU passthrough
    @(negedge clk);
    alu_c = MI_ADDI; alu_c.alu_src = 1'b0;
    valid_i = 1'b1; control_i = alu_c; alu_i = 32'h1234; addr_rd_i = 5'd3; pc_plus4_i = 32'h88;
    #1;
    check("alu stall/req", {30'h0, stall_o, dmem_req_o}, 32'h0);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check("alu valid_o", {31'h0, valid_o}, 32'h1);
    check("alu alu_o", alu_o, 32'h1234);
    check("alu rd/pc", {addr_rd_o, pc_plus4_o[26:0]}, {5'd3, 27'h88});
    check("alu control_o", 32'(control_o), 32'(alu_c));
    check("alu load_data", load_data_o, 32'h0);

    run_mem("LB",  mk_ctrl(1'b1, 1'b0, F3_B),  32'h103, 32'h0, 0, 1,
            32'h80FF_0000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    run_mem("LBU", mk_ctrl(1'b1, 1'b0, F3_BU), 32'h103, 32'h0, 0, 1,
            32'h80FF_0000, 4'b1000, 32'h0, 32'h0000_0080);
    run_mem("SH",  mk_ctrl(1'b0, 1'b1, F3_H),  32'h202, 32'hAAAA_BEEF, 3, 2,
            32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    run_mem("LH",  mk_ctrl(1'b1, 1'b0, F3_H),  32'h206, 32'h0, 1, 1,
            32'h8001_1234, 4'b1100, 32'h0, 32'hFFFF_8001);
    run_mem("SW",  mk_ctrl(1'b0, 1'b1, F3_W),  32'h20C, 32'hCAFE_F00D, 0, 2,
            32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0);

    // Misaligned word load
    @(negedge clk);
    valid_i = 1'b1; control_i = mk_ctrl(1'b1, 1'b0, F3_W); alu_i = 32'h301;
    #1;
    check("mis req/stall", {30'h0, dmem_req_o, stall_o}, 32'h0);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check("mis valid/flag", {30'h0, valid_o, misalign_o}, 32'h3);
    check("mis rf_we", {31'h0, control_o.rf_we}, 32'h0);

    // Timeout: granted, rvalid never arrives
    @(negedge clk);
    valid_i = 1'b1; control_i = mk_ctrl(1'b1, 1'b0, F3_W); alu_i = 32'h400; dmem_gnt_i = 1'b1;
    stalls = 0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin @(negedge clk); dmem_gnt_i = 1'b0; end
      #1;
      if (stall_o) stalls++;
    end
    check("to stall last", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check("to stalls", stalls, 16);
    check("to err/valid", {30'h0, bus_err_o, valid_o}, 32'h3);
    check("to rf_we", {31'h0, control_o.rf_we}, 32'h0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    #1;
    check("stray rvalid", {valid_o, bus_err_o, stall_o, dmem_req_o, load_data_o[27:0]}, 32'h0);

    // Reset in S_REQ
    @(negedge clk);
    valid_i = 1'b1; control_i = mk_ctrl(1'b0, 1'b1, F3_W); alu_i = 32'h500; mem_data_i = 32'h1;
    @(negedge clk);
    #1;
    check("rq req high", {31'h0, dmem_req_o}, 32'h1);
    #2 rst_i = 1'b1;
    #1;
    check("rq req drop", {31'h0, dmem_req_o}, 32'h0);
    check("rq stall", {31'h0, stall_o}, 32'h0);
    check("rq control_o", 32'(control_o), 32'(MI_ADDI));
    check("rq outputs", {valid_o, misalign_o, bus_err_o, alu_o[28:0]}, 32'h0);
    check("rq bus", dmem_addr_o | dmem_wdata_o | {27'h0, dmem_we_o, dmem_be_o}, 32'h0);
    @(negedge clk);
    valid_i = 1'b0; rst_i = 1'b0; dmem_rvalid_i = 1'b1;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    #1;
    check("late rvalid", {30'h0, valid_o, stall_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
